barrel_shifter: RTL and testbench

- 32-bit ARM-style operand shifter with a registered output.
- Applies LSL, LSR, ASR or ROR/RRX to the second operand under control of a 2-bit type and a 5-bit amount, and produces the shifter carry-out.
- Sits between the register-file read port and the ALU B input.
- Result and carry are captured on the clock edge after inputs are presented.

---
 rtl/barrel_shifter.sv | 122 ++++++++++++
 tb/tb_barrel_shifter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - 32-bit ARM-style operand shifter with registered result and carry
//
// Purpose: applies LSL, LSR, ASR or ROR/RRX to the ALU B operand and
// produces the shifter carry-out; both are registered (one-cycle latency).
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset (clears Output_Bus and Cout)
//   Enable      1 = shift, 0 = pass Input_Bus and Cin straight through
//   Input_Bus   32-bit operand
//   Shift_Type  00 LSL, 01 LSR, 10 ASR, 11 ROR (amount 0 selects RRX)
//   Shift_Amt   shift distance 0..31
//   Cin         current C flag (carry pass-through and RRX fill)
//   Output_Bus  registered shifted result
//   Cout        registered shifter carry-out

module barrel_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable,
  input  logic [31:0] Input_Bus,
  input  logic [1:0]  Shift_Type,
  input  logic [4:0]  Shift_Amt,
  input  logic        Cin,
  output logic [31:0] Output_Bus,
  output logic        Cout
);

  localparam logic [1:0] TYPE_LSL = 2'b00;
  localparam logic [1:0] TYPE_ASR = 2'b10;
  localparam logic [1:0] TYPE_ROR = 2'b11;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31 - i];
    end
    return r;
  endfunction

  // One mux stage of the log shifter. sh is always a constant at the call
  // site, so each call reduces to fixed wiring plus a 2:1 mux.
  function automatic logic [31:0] shift_stage(
    input logic [31:0] v,
    input logic        take,
    input logic        rotate,
    input logic        fill,
    input int          sh
  );
    logic [31:0] fill_mask;
    fill_mask = fill ? ~(32'hFFFF_FFFF >> sh) : 32'h0000_0000;
    if (!take) begin
      return v;
    end else if (rotate) begin
      return (v >> sh) | (v << (32 - sh));
    end else begin
      return (v >> sh) | fill_mask;
    end
  endfunction

  logic        is_lsl;
  logic        is_ror;
  logic        fill_bit;
  logic [31:0] net_in;
  logic [31:0] s1, s2, s4, s8, s16;
  logic [4:0]  lsl_carry_idx;
  logic [4:0]  rsh_carry_idx;
  logic [31:0] next_result;
  logic        next_carry;

  assign is_lsl   = (Shift_Type == TYPE_LSL);
  assign is_ror   = (Shift_Type == TYPE_ROR);
  assign fill_bit = (Shift_Type == TYPE_ASR) & Input_Bus[31];

  // LSL shares the right-shift network: reverse the bits going in and
  // coming out, so a left shift becomes a zero-filled right shift.
  assign net_in = is_lsl ? reverse32(Input_Bus) : Input_Bus;

  always_comb begin
    s1  = shift_stage(net_in, Shift_Amt[0], is_ror, fill_bit, 1);
    s2  = shift_stage(s1,     Shift_Amt[1], is_ror, fill_bit, 2);
    s4  = shift_stage(s2,     Shift_Amt[2], is_ror, fill_bit, 4);
    s8  = shift_stage(s4,     Shift_Amt[3], is_ror, fill_bit, 8);
    s16 = shift_stage(s8,     Shift_Amt[4], is_ror, fill_bit, 16);
  end

  // Carry is the last bit shifted out: bit 32-n for LSL (5-bit wrap of -n
  // gives exactly that for n=1..31), bit n-1 for the right-going shifts.
  assign lsl_carry_idx = 5'd0 - Shift_Amt;
  assign rsh_carry_idx = Shift_Amt - 5'd1;

  always_comb begin
    next_result = Input_Bus;
    next_carry  = Cin;
    if (Enable) begin
      if (Shift_Amt == 5'd0) begin
        if (is_ror) begin
          // RRX: rotate right by one through the carry flag
          next_result = {Cin, Input_Bus[31:1]};
          next_carry  = Input_Bus[0];
        end
      end else if (is_lsl) begin
        next_result = reverse32(s16);
        next_carry  = Input_Bus[lsl_carry_idx];
      end else begin
        next_result = s16;
        next_carry  = Input_Bus[rsh_carry_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output_Bus <= 32'h0000_0000;
      Cout       <= 1'b0;
    end else begin
      Output_Bus <= next_result;
      Cout       <= next_carry;
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// tb/tb_barrel_shifter.sv - table-driven self-checking bench for barrel_shifter

module tb_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] in_bus;
  logic [1:0]  typ;
  logic [4:0]  amt;
  logic        cin;
  logic [31:0] out_bus;
  logic        cout;

  int total = 0;
  int bad   = 0;

  barrel_shifter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Enable     (en),
    .Input_Bus  (in_bus),
    .Shift_Type (typ),
    .Shift_Amt  (amt),
    .Cin        (cin),
    .Output_Bus (out_bus),
    .Cout       (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [4:0]  amt;
    logic        cin;
    logic [31:0] exp_r;
    logic        exp_c;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [31:0] d, input logic [1:0] t,
                     input logic [4:0] a, input logic c,
                     input logic [31:0] er, input logic ec);
    vec_t v;
    v.en = e; v.data = d; v.typ = t; v.amt = a; v.cin = c;
    v.exp_r = er; v.exp_c = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got_r, input logic got_c,
                       input logic [31:0] exp_r, input logic exp_c);
    total++;
    if (got_r !== exp_r || got_c !== exp_c) begin
      bad++;
      $display("FAIL %s: got result=%h carry=%b, need result=%h carry=%b",
               name, got_r, got_c, exp_r, exp_c);
    end
  endtask

  task automatic drive(input logic e, input logic [31:0] d, input logic [1:0] t,
                       input logic [4:0] a, input logic c);
    en = e; in_bus = d; typ = t; amt = a; cin = c;
  endtask

  initial begin
    // LSL
    add(1, 32'h1, 2'b00, 5'd0, 1, 32'h1,  1);
    add(1, 32'h1, 2'b00, 5'd1, 1, 32'h2,  0);
    add(1, 32'h1, 2'b00, 5'd2, 1, 32'h4,  0);
    add(1, 32'h1, 2'b00, 5'd3, 1, 32'h8,  0);
    add(1, 32'h1, 2'b00, 5'd4, 1, 32'h10, 0);
    add(1, 32'h1, 2'b00, 5'd5, 1, 32'h20, 0);
    add(1, 32'h8000_0001, 2'b00, 5'd1,  0, 32'h0000_0002, 1);
    add(1, 32'h0000_0001, 2'b00, 5'd31, 1, 32'h8000_0000, 0);
    add(1, 32'h0000_0002, 2'b00, 5'd31, 0, 32'h0000_0000, 1);
    // LSR
    add(1, 32'h20, 2'b01, 5'd0, 0, 32'h20, 0);
    add(1, 32'h20, 2'b01, 5'd1, 0, 32'h10, 0);
    add(1, 32'h20, 2'b01, 5'd2, 0, 32'h8,  0);
    add(1, 32'h20, 2'b01, 5'd3, 0, 32'h4,  0);
    add(1, 32'h20, 2'b01, 5'd4, 0, 32'h2,  0);
    add(1, 32'h20, 2'b01, 5'd5, 0, 32'h1,  0);
    add(1, 32'h20, 2'b01, 5'd6, 0, 32'h0,  1);
    add(1, 32'h8000_0000, 2'b01, 5'd31, 1, 32'h0000_0001, 0);
    add(1, 32'hC000_0000, 2'b01, 5'd31, 0, 32'h0000_0001, 1);
    // ASR
    add(1, 32'h8000_0000, 2'b10, 5'd0, 1, 32'h8000_0000, 1);
    add(1, 32'h8000_0000, 2'b10, 5'd1, 1, 32'hC000_0000, 0);
    add(1, 32'h8000_0000, 2'b10, 5'd2, 1, 32'hE000_0000, 0);
    add(1, 32'h8000_0000, 2'b10, 5'd3, 1, 32'hF000_0000, 0);
    add(1, 32'h8000_0000, 2'b10, 5'd4, 1, 32'hF800_0000, 0);
    add(1, 32'h8000_0000, 2'b10, 5'd5, 1, 32'hFC00_0000, 0);
    add(1, 32'h0000_0000, 2'b10, 5'd0, 0, 32'h0000_0000, 0);
    add(1, 32'h8000_0000, 2'b10, 5'd31, 0, 32'hFFFF_FFFF, 0);
    add(1, 32'h4000_0000, 2'b10, 5'd30, 1, 32'h0000_0001, 0);
    // ROR / RRX
    add(1, 32'h2, 2'b11, 5'd0, 1, 32'h8000_0001, 0);
    add(1, 32'h2, 2'b11, 5'd1, 1, 32'h0000_0001, 0);
    add(1, 32'h2, 2'b11, 5'd2, 1, 32'h8000_0000, 1);
    add(1, 32'h2, 2'b11, 5'd3, 1, 32'h4000_0000, 0);
    add(1, 32'h2, 2'b11, 5'd5, 1, 32'h1000_0000, 0);
    add(1, 32'h1234_5678, 2'b11, 5'd16, 0, 32'h5678_1234, 0);
    add(1, 32'h0000_0003, 2'b11, 5'd0, 0, 32'h0000_0001, 1);
    // Enable=0 ignores type and amount
    add(0, 32'hDEAD_BEEF, 2'b11, 5'd5,  0, 32'hDEAD_BEEF, 0);
    add(0, 32'h8000_0000, 2'b10, 5'd31, 1, 32'h8000_0000, 1);

    // reset asserted before any clock edge clears outputs at once
    rst_n = 1'b1;
    drive(1, 32'hFFFF_FFFF, 2'b00, 5'd0, 1);
    #1 rst_n = 1'b0;
    #1 check("reset_async", out_bus, cout, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("reset_hold", out_bus, cout, 32'h0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release_load", out_bus, cout, 32'hFFFF_FFFF, 1'b1);

    // bypass sweep with both carry values
    for (int c = 0; c < 2; c++) begin
      for (int i = 1; i <= 32; i++) begin
        @(negedge clk) drive(0, 32'(i), 2'b00, 5'd0, c[0]);
        @(posedge clk); #1;
        check($sformatf("bypass_%0d_cin%0d", i, c), out_bus, cout, 32'(i), c[0]);
      end
    end

    // table vectors, one per cycle
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk) drive(vecs[k].en, vecs[k].data, vecs[k].typ, vecs[k].amt, vecs[k].cin);
      @(posedge clk); #1;
      check($sformatf("vec_%0d", k), out_bus, cout, vecs[k].exp_r, vecs[k].exp_c);
    end

    // output holds for the whole cycle after inputs change mid-cycle
    @(negedge clk) drive(1, 32'h1, 2'b00, 5'd4, 0);
    @(posedge clk); #1;
    drive(1, 32'hFFFF_FFFF, 2'b10, 5'd1, 1);
    #3 check("hold_midcycle", out_bus, cout, 32'h10, 1'b0);
    @(posedge clk); #1;
    check("next_after_hold", out_bus, cout, 32'hFFFF_FFFF, 1'b1);

    // reset mid-stream discards the in-flight result
    @(negedge clk) drive(1, 32'h2, 2'b11, 5'd2, 1);
    #1 rst_n = 1'b0;
    #1 check("reset_midstream", out_bus, cout, 32'h0, 1'b0);
    @(posedge clk); #1;
    check("reset_midstream_edge", out_bus, cout, 32'h0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_midstream_reset", out_bus, cout, 32'h8000_0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
